// File: rtl/dynamixel_status_receiver.sv
// dynamixel_status_receiver
//
// Receives Dynamixel Protocol 2.0 status packets from the half-duplex servo
// bus whenever the local transmitter has released it. It deserialises 8N1
// UART bytes, hunts for the FF FF FD 00 header, and checks LEN, the
// instruction byte (0x55) and the CRC-16. It then publishes the servo ID,
// the error byte, the parameter count and the first four parameter bytes.
//
// Optional feature macro: DYNAMIXEL_UNSTUFF_EN
//   When defined, a 0xFD that follows an FF FF FD sequence inside the
//   parameter field is treated as a stuffing byte. It is counted and
//   CRC'd, but it is not stored in param_value.
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   listen        in   1 = bus released; 0 forces RX/parser idle
//   pin           in   raw asynchronous bus input, idle high
//   status_valid  out  one-cycle pulse, good packet accepted
//   status_id     out  servo ID of last good packet
//   status_error  out  error byte of last good packet
//   param_count   out  LEN-4 of last good packet
//   param_value   out  first four param bytes, little-endian
//   crc_error     out  one-cycle pulse, CRC mismatch
//   packet_error  out  one-cycle pulse, framing error / LEN<4 / timeout
module dynamixel_status_receiver #(
  parameter int unsigned clocks_per_bit = 3,
  parameter int unsigned timeout_bits   = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        listen,
  input  logic        pin,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [7:0]  status_error,
  output logic [15:0] param_count,
  output logic [31:0] param_value,
  output logic        crc_error,
  output logic        packet_error
);

  localparam int unsigned CNT_W = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam int unsigned TO_W  = $clog2(timeout_bits + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(clocks_per_bit / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(timeout_bits - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(timeout_bits);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [3:0] {
    P_HUNT, P_H2, P_H3, P_RSV, P_ID, P_LEN_L, P_LEN_H,
    P_INST, P_ERR, P_PARAM, P_CRC_L, P_CRC_H
  } par_state_t;

  // Byte-wide CRC-16 update: poly 0x8005, unreflected.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    end
    return r;
  endfunction

  // ---- stage p0/p1: pin synchroniser, p2: previous sample for edge detect
  logic pin_meta_p0, pin_sync_p1, pin_prev_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pin_meta_p0 <= 1'b1;
      pin_sync_p1 <= 1'b1;
      pin_prev_p2 <= 1'b1;
    end else begin
      pin_meta_p0 <= pin;
      pin_sync_p1 <= pin_meta_p0;
      pin_prev_p2 <= pin_sync_p1;
    end
  end

  logic start_edge;
  assign start_edge = pin_prev_p2 & ~pin_sync_p1;

  // ---- UART receiver
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_byte;
  logic             sample_tick;
  logic             data_sample;
  logic             byte_done;
  logic             frame_err;

  assign sample_tick = (rx_cnt == CNT_LAST);
  assign data_sample = (rx_state == RX_DATA) && sample_tick;
  assign byte_done   = listen && (rx_state == RX_STOP) && sample_tick && pin_sync_p1;
  assign frame_err   = listen && (rx_state == RX_STOP) && sample_tick && !pin_sync_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else if (!listen) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (start_edge) rx_state <= RX_START;
        end
        RX_START: begin
          // Mid-start-bit re-check rejects glitches shorter than half a bit.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= pin_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (sample_tick) begin
            rx_cnt <= '0;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (sample_tick) begin
            rx_cnt   <= '0;
            rx_state <= pin_sync_p1 ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          rx_cnt <= '0;
          if (pin_sync_p1) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (data_sample) rx_byte <= {pin_sync_p1, rx_byte[7:1]};
  end

  // ---- inter-byte timeout: bit periods since the most recent start edge
  logic [CNT_W-1:0] to_tick;
  logic [TO_W-1:0]  to_periods;
  par_state_t       par_state;
  logic             timeout_hit;

  assign timeout_hit = (par_state != P_HUNT) && (to_tick == CNT_LAST) && (to_periods == TO_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_tick    <= '0;
      to_periods <= '0;
    end else if (!listen || start_edge) begin
      to_tick    <= '0;
      to_periods <= '0;
    end else if (to_tick == CNT_LAST) begin
      to_tick <= '0;
      if (to_periods != TO_MAX) to_periods <= to_periods + 1'b1;
    end else begin
      to_tick <= to_tick + 1'b1;
    end
  end

  // ---- packet parser
  logic [15:0] remaining;
  logic [2:0]  param_idx;
  logic [7:0]  stage_id;
  logic [7:0]  stage_err;
  logic [15:0] stage_len;
  logic [31:0] stage_param;
  logic [15:0] crc;
  logic [7:0]  crc_rx_l;
  logic [15:0] len_full;
  logic        stuff_byte;
  logic        slot_free;

  assign len_full  = {rx_byte, stage_len[7:0]};
  assign slot_free = (param_idx < 3'd4) && !stuff_byte;

`ifdef DYNAMIXEL_UNSTUFF_EN
  // Last three parameter bytes; FF FF FD here marks the next 0xFD as stuffing.
  logic [23:0] hist;
  assign stuff_byte = (par_state == P_PARAM) && (hist == 24'hFFFFFD) && (rx_byte == 8'hFD);

  always_ff @(posedge clock) begin
    if (byte_done) begin
      if (par_state == P_ERR)        hist <= '0;
      else if (par_state == P_PARAM) hist <= stuff_byte ? 24'h0 : {hist[15:0], rx_byte};
    end
  end
`else
  assign stuff_byte = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_state    <= P_HUNT;
      remaining    <= '0;
      param_idx    <= '0;
      status_valid <= 1'b0;
      crc_error    <= 1'b0;
      packet_error <= 1'b0;
      status_id    <= '0;
      status_error <= '0;
      param_count  <= '0;
      param_value  <= '0;
    end else begin
      status_valid <= 1'b0;
      crc_error    <= 1'b0;
      packet_error <= 1'b0;
      if (!listen) begin
        par_state <= P_HUNT;
        remaining <= '0;
        param_idx <= '0;
      end else if (frame_err) begin
        if (par_state != P_HUNT) packet_error <= 1'b1;
        par_state <= P_HUNT;
      end else if (byte_done) begin
        case (par_state)
          P_HUNT:  if (rx_byte == 8'hFF) par_state <= P_H2;
          P_H2:    par_state <= (rx_byte == 8'hFF) ? P_H3 : P_HUNT;
          P_H3: begin
            if (rx_byte == 8'hFD)      par_state <= P_RSV;
            else if (rx_byte != 8'hFF) par_state <= P_HUNT;
          end
          P_RSV:   par_state <= (rx_byte == 8'h00) ? P_ID : P_HUNT;
          P_ID:    par_state <= P_LEN_L;
          P_LEN_L: par_state <= P_LEN_H;
          P_LEN_H: begin
            if (len_full < 16'd4) begin
              packet_error <= 1'b1;
              par_state    <= P_HUNT;
            end else begin
              remaining <= len_full - 16'd4;
              par_state <= P_INST;
            end
          end
          P_INST:  par_state <= (rx_byte == 8'h55) ? P_ERR : P_HUNT;
          P_ERR: begin
            param_idx <= '0;
            par_state <= (remaining == 16'd0) ? P_CRC_L : P_PARAM;
          end
          P_PARAM: begin
            remaining <= remaining - 16'd1;
            if (slot_free) param_idx <= param_idx + 3'd1;
            if (remaining == 16'd1) par_state <= P_CRC_L;
          end
          P_CRC_L: par_state <= P_CRC_H;
          P_CRC_H: begin
            if ({rx_byte, crc_rx_l} == crc) begin
              status_valid <= 1'b1;
              status_id    <= stage_id;
              status_error <= stage_err;
              param_count  <= stage_len - 16'd4;
              param_value  <= stage_param;
            end else begin
              crc_error <= 1'b1;
            end
            par_state <= P_HUNT;
          end
          default: par_state <= P_HUNT;
        endcase
      end else if (timeout_hit) begin
        packet_error <= 1'b1;
        par_state    <= P_HUNT;
      end
    end
  end

  // Staging registers and running CRC; contents are only consumed after a
  // full header has been seen, so they need no reset.
  always_ff @(posedge clock) begin
    if (byte_done) begin
      case (par_state)
        P_HUNT:  crc <= crc_byte(16'h0000, rx_byte);
        // Extra 0xFF in H3 is leading noise: CRC keeps covering FF FF only.
        P_H3:    if (rx_byte == 8'hFD) crc <= crc_byte(crc, rx_byte);
        P_H2, P_RSV, P_INST: crc <= crc_byte(crc, rx_byte);
        P_ID: begin
          crc      <= crc_byte(crc, rx_byte);
          stage_id <= rx_byte;
        end
        P_LEN_L: begin
          crc             <= crc_byte(crc, rx_byte);
          stage_len[7:0]  <= rx_byte;
        end
        P_LEN_H: begin
          crc             <= crc_byte(crc, rx_byte);
          stage_len[15:8] <= rx_byte;
        end
        P_ERR: begin
          crc         <= crc_byte(crc, rx_byte);
          stage_err   <= rx_byte;
          stage_param <= '0;
        end
        P_PARAM: begin
          crc <= crc_byte(crc, rx_byte);
          if (slot_free) stage_param[{param_idx[1:0], 3'b000} +: 8] <= rx_byte;
        end
        P_CRC_L: crc_rx_l <= rx_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Directed bench for dynamixel_status_receiver: drives 8N1 bytes on pin and
// checks pulses and captured status fields against hand-derived values.
module tb_dynamixel_status_receiver;

  localparam int CPB = 3;

  logic        clock;
  logic        reset_n;
  logic        listen;
  logic        pin;
  logic        status_valid;
  logic [7:0]  status_id;
  logic [7:0]  status_error;
  logic [15:0] param_count;
  logic [31:0] param_value;
  logic        crc_error;
  logic        packet_error;

  dynamixel_status_receiver #(
    .clocks_per_bit(CPB),
    .timeout_bits  (32)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .listen      (listen),
    .pin         (pin),
    .status_valid(status_valid),
    .status_id   (status_id),
    .status_error(status_error),
    .param_count (param_count),
    .param_value (param_value),
    .crc_error   (crc_error),
    .packet_error(packet_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_crc = 0;
  int n_pkt = 0;

  always @(negedge clock) begin
    if (status_valid) n_valid++;
    if (crc_error)    n_crc++;
    if (packet_error) n_pkt++;
  end

  logic [7:0] pkt [0:31];
  int         pkt_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    pin = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      repeat (CPB) @(posedge clock);
    end
    pin = stop_bit;
    repeat (CPB) @(posedge clock);
    pin = 1'b1;
    repeat (CPB) @(posedge clock);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pkt[i], 1'b1);
  endtask

  // Bytes given most-significant first in the right-aligned vector.
  task automatic load(input logic [255:0] v, input int n);
    for (int i = 0; i < n; i++) pkt[i] = v[8*(n-1-i) +: 8];
    pkt_len = n;
  endtask

  // Bit-serial reference CRC-16 (0x8005, init 0, MSB first).
  function automatic logic [15:0] model_crc(input int first, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = first; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ pkt[i][j];
        c  = c << 1;
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic append_crc(input int first);
    logic [15:0] c;
    c = model_crc(first, pkt_len);
    pkt[pkt_len]     = c[7:0];
    pkt[pkt_len + 1] = c[15:8];
    pkt_len += 2;
  endtask

  int v0, c0, p0;
  task automatic snap();
    v0 = n_valid; c0 = n_crc; p0 = n_pkt;
  endtask

  logic [31:0] exp_val;
  int          waited;

  initial begin
    reset_n = 1'b0;
    listen  = 1'b1;
    pin     = 1'b1;
    repeat (4) @(posedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);

    // Reset state
    check("rst_valid",  {31'd0, status_valid}, 32'd0);
    check("rst_crcerr", {31'd0, crc_error},    32'd0);
    check("rst_pkterr", {31'd0, packet_error}, 32'd0);
    check("rst_id",     {24'd0, status_id},    32'd0);
    check("rst_err",    {24'd0, status_error}, 32'd0);
    check("rst_count",  {16'd0, param_count},  32'd0);
    check("rst_value",  param_value,           32'd0);

    // Ping status packet with known-good CRC
    snap();
    load(256'hFFFFFD0001070055000604_26655D, 14);
    send_range(0, 13);
    wait_bits(2);
    @(negedge clock);
    check("ping_valid_cnt", n_valid - v0, 1);
    check("ping_crc_cnt",   n_crc - c0,   0);
    check("ping_pkt_cnt",   n_pkt - p0,   0);
    check("ping_id",    {24'd0, status_id},    32'h01);
    check("ping_err",   {24'd0, status_error}, 32'h00);
    check("ping_count", {16'd0, param_count},  32'd3);
    check("ping_value", param_value,           32'h00260406);

    // Same packet, corrupted CRC high byte
    snap();
    pkt[13] = 8'h5C;
    send_range(0, 13);
    wait_bits(2);
    @(negedge clock);
    check("badcrc_crc_cnt",   n_crc - c0,   1);
    check("badcrc_valid_cnt", n_valid - v0, 0);
    check("badcrc_id_hold",   {24'd0, status_id}, 32'h01);
    check("badcrc_val_hold",  param_value, 32'h00260406);

    // Extra leading 0xFF before the header, LEN = 4 (no params)
    snap();
    load(256'hFFFFFFFD0002040055_80, 10);
    append_crc(1);
    send_range(0, pkt_len - 1);
    wait_bits(2);
    @(negedge clock);
    check("noparam_valid_cnt", n_valid - v0, 1);
    check("noparam_id",    {24'd0, status_id},    32'h02);
    check("noparam_err",   {24'd0, status_error}, 32'h80);
    check("noparam_count", {16'd0, param_count},  32'd0);
    check("noparam_value", param_value,           32'd0);

    // LEN < 4
    snap();
    load(256'hFFFFFD00010300, 7);
    send_range(0, 6);
    wait_bits(2);
    @(negedge clock);
    check("shortlen_pkt_cnt", n_pkt - p0, 1);

    // Inter-byte timeout after LEN_H
    snap();
    load(256'hFFFFFD00030700, 7);
    send_range(0, 6);
    wait_bits(15);
    @(negedge clock);
    check("timeout_not_early", n_pkt - p0, 0);
    waited = 0;
    while ((n_pkt - p0) == 0 && waited < 25 * CPB) begin
      @(negedge clock);
      waited++;
    end
    check("timeout_pkt_cnt", n_pkt - p0, 1);
    snap();
    load(256'hFFFFFD0001070055000604_26655D, 14);
    send_range(0, 13);
    wait_bits(2);
    @(negedge clock);
    check("after_timeout_valid", n_valid - v0, 1);

    // listen dropped mid-packet, then a full good packet
    snap();
    send_range(0, 4);
    listen = 1'b0;
    send_range(5, 13);
    wait_bits(2);
    listen = 1'b1;
    wait_bits(2);
    @(negedge clock);
    check("listen_off_no_pulse", (n_valid - v0) + (n_crc - c0) + (n_pkt - p0), 0);
    send_range(0, 13);
    wait_bits(2);
    @(negedge clock);
    check("listen_on_valid", n_valid - v0, 1);
    check("listen_on_errs",  (n_crc - c0) + (n_pkt - p0), 0);

    // Framing error mid-packet
    snap();
    send_range(0, 4);
    send_byte(8'h07, 1'b0);
    wait_bits(2);
    @(negedge clock);
    check("frame_pkt_cnt",   n_pkt - p0,   1);
    check("frame_valid_cnt", n_valid - v0, 0);

    // Params containing FF FF FD FD, LEN = 9
    snap();
    load(256'hFFFFFD0005090055_00_FFFFFDFD11, 14);
    append_crc(0);
    send_range(0, pkt_len - 1);
    wait_bits(2);
    @(negedge clock);
`ifdef DYNAMIXEL_UNSTUFF_EN
    exp_val = 32'h11FDFFFF;
`else
    exp_val = 32'hFDFDFFFF;
`endif
    check("stuff_valid_cnt", n_valid - v0, 1);
    check("stuff_id",    {24'd0, status_id},   32'h05);
    check("stuff_count", {16'd0, param_count}, 32'd5);
    check("stuff_value", param_value,          exp_val);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
